// File: rtl/ay_pkg.sv
// Shared AY-3-8910 PSG definitions: shape bit indices, widths, envelope state and level mapping.
// Build option AY_ENV_YM_32STEP_EN selects the YM2149 32-step envelope.
package ay_pkg;

    localparam int PERIOD_W = 16;
    localparam int LEVEL_W  = 5;

    // Bit positions inside r13[3:0]
    localparam int ENV_CONT = 3;
    localparam int ENV_ATT  = 2;
    localparam int ENV_ALT  = 1;
    localparam int ENV_HOLD = 0;

`ifdef AY_ENV_YM_32STEP_EN
    localparam int ENV_STEPS = 32;
`else
    localparam int ENV_STEPS = 16;
`endif

    localparam int STEP_W = $clog2(ENV_STEPS);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(ENV_STEPS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_HIGH = '1;

    typedef enum logic {
        ENV_RUN     = 1'b0,
        ENV_HOLDING = 1'b1
    } env_state_t;

    // Ramp position and direction to output amplitude; AY levels expand to 5 bits with a 1 LSB.
    function automatic logic [LEVEL_W-1:0] env_level_of(input logic [STEP_W-1:0] step,
                                                        input logic dir);
        logic [STEP_W-1:0] l;
        l = dir ? step : STEP_LAST - step;
`ifdef AY_ENV_YM_32STEP_EN
        return l;
`else
        return (l == '0) ? '0 : {l, 1'b1};
`endif
    endfunction

endpackage

// File: rtl/ay_period_counter.sv
// Tick-enabled period divider: counts ticks and pulses wrap when count reaches P-1 (period 0 acts as 1).
// Shared by the envelope, tone and noise generators.
module ay_period_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] period,
    output logic         wrap
);

    logic [W-1:0] count;
    logic [W-1:0] limit;
    logic         at_limit;

    // ">=" rather than "==" so a period shortened below the current count wraps on the next tick.
    assign limit    = (period == '0) ? '0 : period - 1'b1;
    assign at_limit = (count >= limit);
    assign wrap     = tick && !clear && at_limit;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= at_limit ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ay_envelope.sv
// AY-3-8910 envelope generator: period-divided step ramp shaped by r13 (CONT/ATT/ALT/HOLD).
// Build option AY_ENV_YM_32STEP_EN selects the YM2149 32-step ramp (via ay_pkg).
module ay_envelope #(
    parameter int PERIOD_W = 16,
    parameter int LEVEL_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_tick,
    input  logic [PERIOD_W-1:0] env_period,
    input  logic [3:0]          env_shape,
    input  logic                env_restart,
    output logic [LEVEL_W-1:0]  env_level,
    output logic                env_holding,
    output logic                env_cycle_tick
);
    import ay_pkg::*;

    env_state_t        state;
    logic [3:0]        shape;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_next;
    logic              advance;
    logic              dir_after_ramp;

    assign step_next      = step + 1'b1;
    assign dir_after_ramp = dir ^ shape[ENV_ALT];

    ay_period_counter #(.W(PERIOD_W)) u_period (
        .clk    (clk),
        .reset  (reset),
        .clear  (env_restart),
        .tick   (step_tick && (state == ENV_RUN)),
        .period (env_period),
        .wrap   (advance)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ENV_HOLDING;
            shape          <= '0;
            dir            <= 1'b0;
            step           <= '0;
            env_level      <= '0;
            env_holding    <= 1'b1;
            env_cycle_tick <= 1'b0;
        end else begin
            env_cycle_tick <= 1'b0;
            if (env_restart) begin
                // Restart wins over a coincident step_tick; the counter clears on the same edge.
                state       <= ENV_RUN;
                shape       <= env_shape;
                dir         <= env_shape[ENV_ATT];
                step        <= '0;
                env_holding <= 1'b0;
                env_level   <= env_level_of('0, env_shape[ENV_ATT]);
            end else if (advance) begin
                if (step != STEP_LAST) begin
                    step      <= step_next;
                    env_level <= env_level_of(step_next, dir);
                end else begin
                    env_cycle_tick <= 1'b1;
                    if (!shape[ENV_CONT]) begin
                        state       <= ENV_HOLDING;
                        env_holding <= 1'b1;
                        env_level   <= '0;
                    end else if (shape[ENV_HOLD]) begin
                        state       <= ENV_HOLDING;
                        env_holding <= 1'b1;
                        env_level   <= (shape[ENV_ATT] ^ shape[ENV_ALT]) ? LEVEL_HIGH : '0;
                    end else begin
                        step      <= '0;
                        dir       <= dir_after_ramp;
                        env_level <= env_level_of('0, dir_after_ramp);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ay_envelope.sv
// Directed and randomized bench for ay_envelope against a closed-form envelope model.
module tb_ay_envelope;

`ifdef AY_ENV_YM_32STEP_EN
    localparam int STEPS = 32;
`else
    localparam int STEPS = 16;
`endif
    localparam int MAXL = STEPS - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_tick = 1'b0;
    logic        env_restart = 1'b0;
    logic [15:0] env_period = 16'd1;
    logic [3:0]  env_shape = 4'd0;
    logic [4:0]  env_level;
    logic        env_holding;
    logic        env_cycle_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ay_envelope dut (
        .clk            (clk),
        .reset          (reset),
        .step_tick      (step_tick),
        .env_period     (env_period),
        .env_shape      (env_shape),
        .env_restart    (env_restart),
        .env_level      (env_level),
        .env_holding    (env_holding),
        .env_cycle_tick (env_cycle_tick)
    );

    // Model: n = completed step advances since restart; ramp r = n / STEPS, position n % STEPS.
    function automatic logic model_hold(input logic [3:0] sh, input int n);
        return (n >= STEPS) && (!sh[3] || sh[0]);
    endfunction

    function automatic logic [31:0] model_level(input logic [3:0] sh, input int n);
        int r;
        int pos;
        int l;
        logic d;
        r   = n / STEPS;
        pos = n % STEPS;
        if (r >= 1 && !sh[3]) return 0;
        if (r >= 1 && sh[0]) return (sh[2] ^ sh[1]) ? 31 : 0;
        d = sh[2] ^ (sh[1] & r[0]);
        l = d ? pos : MAXL - pos;
        if (STEPS == 32) return l;
        return (l == 0) ? 0 : 2 * l + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, release 1 time unit after the rising edge.
    task automatic cyc(input logic tk, input logic rs, input logic rst);
        @(negedge clk);
        step_tick   = tk;
        env_restart = rs;
        reset       = rst;
        @(posedge clk);
        #1;
        step_tick   = 1'b0;
        env_restart = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic run_env(input logic [3:0] sh, input logic [15:0] per, input int ticks,
                           output int pulses);
        int pe;
        int n;
        int gap;
        logic exp_pulse;
        pe = (per == 0) ? 1 : int'(per);
        pulses = 0;
        env_shape  = sh;
        env_period = per;
        cyc(1'b0, 1'b1, 1'b0);
        chk("restart_level", env_level, model_level(sh, 0));
        chk("restart_holding", env_holding, 0);
        chk("restart_pulse", env_cycle_tick, 0);
        env_shape = 4'($urandom_range(0, 15));
        for (int t = 1; t <= ticks; t++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b0, 1'b0);
                chk("idle_level", env_level, model_level(sh, (t - 1) / pe));
                chk("idle_pulse", env_cycle_tick, 0);
            end
            cyc(1'b1, 1'b0, 1'b0);
            n = t / pe;
            exp_pulse = (t % pe == 0) && (n > 0) && (n % STEPS == 0) && !model_hold(sh, n - 1);
            chk("ramp_level", env_level, model_level(sh, n));
            chk("ramp_holding", env_holding, model_hold(sh, n));
            chk("ramp_pulse", env_cycle_tick, exp_pulse);
            if (env_cycle_tick) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic [3:0] rsh;
        logic [15:0] rper;

        // Reset, then ticks without a restart must not move anything.
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("reset_level", env_level, 0);
        chk("reset_holding", env_holding, 1);
        chk("reset_pulse", env_cycle_tick, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("norestart_level", env_level, 0);
            chk("norestart_holding", env_holding, 1);
            chk("norestart_pulse", env_cycle_tick, 0);
        end

        // Decay once, then 20 extra ticks while held.
        run_env(4'h0, 16'd1, STEPS + 20, pulses);
        chk("decay_pulses", pulses, 1);

        // Triangle: three full ramps, never holding.
        run_env(4'hE, 16'd3, 3 * 3 * STEPS, pulses);
        chk("triangle_pulses", pulses, 3);

        // Hold shapes.
        run_env(4'hB, 16'd2, 2 * STEPS + 10, pulses);
        chk("hold_b_level", env_level, 31);
        run_env(4'hD, 16'd1, STEPS + 10, pulses);
        chk("hold_d_level", env_level, 31);
        run_env(4'hF, 16'd1, STEPS + 10, pulses);
        chk("hold_f_level", env_level, 0);

        // Period 0 acts as period 1.
        run_env(4'h0, 16'd0, STEPS + 5, pulses);
        chk("period0_pulses", pulses, 1);

        // Random shapes and short periods.
        for (int k = 0; k < 6; k++) begin
            rsh  = 4'($urandom_range(0, 15));
            rper = 16'($urandom_range(0, 3));
            run_env(rsh, rper, 2 * STEPS * ((rper == 0) ? 1 : int'(rper)) + 4, pulses);
        end

        // Period reduced from 100 to 2 while count is 50.
        env_shape  = 4'h0;
        env_period = 16'd100;
        cyc(1'b0, 1'b1, 1'b0);
        repeat (50) cyc(1'b1, 1'b0, 1'b0);
        chk("shrink_before", env_level, model_level(4'h0, 0));
        env_period = 16'd2;
        cyc(1'b1, 1'b0, 1'b0);
        chk("shrink_first", env_level, model_level(4'h0, 1));
        cyc(1'b1, 1'b0, 1'b0);
        chk("shrink_second", env_level, model_level(4'h0, 1));
        cyc(1'b1, 1'b0, 1'b0);
        chk("shrink_third", env_level, model_level(4'h0, 2));

        // Restart coincident with a tick at step 9, counter mid-period.
        env_shape  = 4'h0;
        env_period = 16'd2;
        cyc(1'b0, 1'b1, 1'b0);
        repeat (19) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_restart_level", env_level, model_level(4'h0, 9));
        env_shape = 4'h4;
        cyc(1'b1, 1'b1, 1'b0);
        chk("coincident_level", env_level, model_level(4'h4, 0));
        chk("coincident_pulse", env_cycle_tick, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("after_restart_tick1", env_level, model_level(4'h4, 0));
        cyc(1'b1, 1'b0, 1'b0);
        chk("after_restart_tick2", env_level, model_level(4'h4, 1));

        // Reset mid-ramp.
        env_shape  = 4'hE;
        env_period = 16'd1;
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        chk("pre_reset_level", env_level, model_level(4'hE, 5));
        cyc(1'b1, 1'b0, 1'b1);
        chk("midreset_level", env_level, 0);
        chk("midreset_holding", env_holding, 1);
        chk("midreset_pulse", env_cycle_tick, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("postreset_level", env_level, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
